tia_fb_writer: RTL and testbench
================================

Name: tia_fb_writer

Overview:
- Write side of the 160-wide, 7-bit-index framebuffer that the VGA scan-out block reads.
- Takes the TIA pixel stream (colour index plus hblank/vblank/vsync, qualified by a pixel-rate strobe) and converts it to framebuffer write cycles.
- Row-major addresses: addr = y*FB_W + x.
- Locks to vsync, skips the top overscan lines, captures FB_H lines, then idles until the next vsync.

Parameters:
- FB_W, 160, framebuffer width in pixels / max writes per line
- FB_H, 240, lines captured per frame
- TOP_SKIP, 30, lines discarded after vsync before capture begins
- ADDR_W, 16, framebuffer address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- pix_ce  in  1  TIA pixel strobe; all TIA inputs are sampled only on cycles with pix_ce=1
- pix_color  in  7  TIA colour/luma palette index for the current pixel
- hblank  in  1  TIA horizontal blank
- vblank  in  1  TIA vertical blank
- vsync  in  1  TIA vertical sync
- fb_addr  out  ADDR_W  framebuffer write address
- fb_data  out  7  framebuffer write data
- fb_we  out  1  write enable, one-cycle pulse per pixel
- frame_start  out  1  one-cycle pulse on each detected vsync rising edge
- frame_count  out  8  frames started since reset; wraps 255->0

Behaviour:
- Reset (reset=0, async):
  - fb_addr, fb_data, fb_we, frame_start, frame_count all 0.
  - State SYNC; x, y, skip counter, row_base all 0; edge registers vsync_q and hblank_q = 0.
- Edge detection, only on pix_ce=1 cycles; vsync_q and hblank_q update on those cycles only:
  - vs_rise = vsync & !vsync_q
  - hb_rise = hblank & !hblank_q (end of a visible line)
- States:
  - SYNC: no writes. vs_rise -> SKIP.
  - SKIP: each hb_rise increments the skip counter. When the counter reaches TOP_SKIP, go to CAPTURE with x=0, y=0, row_base=0. No writes.
  - CAPTURE, on pix_ce with hblank=0 and x<FB_W:
    - issue write: addr = row_base + x; data = pix_color, or 0 if vblank=1
    - x increments
  - CAPTURE, pixels with x==FB_W: dropped; x saturates at FB_W.
  - CAPTURE, on hb_rise:
    - x resets to 0.
    - If y==FB_H-1, go to DONE.
    - Otherwise y increments and row_base += FB_W. Adder only, no multiplier.
  - DONE: no writes; wait for vs_rise.
- vs_rise in any state (SYNC, SKIP, CAPTURE, DONE):
  - go to SKIP; clear skip counter, x, y, row_base
  - frame_start=1 for exactly one clk; frame_count increments
  - a pixel sampled on the same pix_ce cycle is not written
- Write timing:
  - fb_addr, fb_data and fb_we=1 are registered and appear on the clk cycle after the qualifying pix_ce cycle.
  - fb_we is high for exactly one clk.
  - fb_addr and fb_data hold their last values while fb_we=0.
- Arithmetic: row_base and fb_addr are ADDR_W bits. Maximum address is FB_H*FB_W-1 = 38399; no wrap occurs at default parameters.
- Simultaneous events:
  - vs_rise has priority over hb_rise and over pixel writes.
  - hb_rise and a pixel never coincide, since hblank=1 on that sample.
- pix_ce=0 cycles: all counters and state hold; fb_we=0.

Test Plan:
- Reset mid-frame: deassert reset, drive 3 lines of active pixels with no vsync -> fb_we stays 0; frame_count=0; all outputs 0.
- Normal frame:
  - stimulus: vsync pulse, then 30 lines of 68 hblank + 160 active pixels, then line 31 with first pixel pix_color=0x12
  - response: frame_start pulses once; frame_count=1; first fb_we one clk after that pix_ce, with fb_addr=0, fb_data=0x12
  - response: exactly 160 writes on that line, addresses 0..159
- Addressing and end of frame:
  - pixel x=159 on capture line 5 -> fb_addr=959
  - last pixel of capture line 239 -> fb_addr=38399
  - further lines before the next vsync -> no writes (DONE)
- Overlong line: 175 active pixels in one line -> exactly 160 writes; next line starts at row_base+160.
- vblank during capture: vblank=1 with pix_color=0x55 -> writes continue with fb_data=0.
- vsync mid-capture (at y=100):
  - frame_start pulse; frame_count increments
  - no writes during the next 30 lines
  - next write at fb_addr=0

Source files
------------

// File: rtl/tia_fb_writer.sv
// rtl/tia_fb_writer.sv - converts the TIA pixel stream into row-major framebuffer write cycles
module tia_fb_writer #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 240,
  parameter int TOP_SKIP = 30,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic [6:0]        pix_color,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              vsync,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [6:0]        fb_data,
  output logic              fb_we,
  output logic              frame_start,
  output logic [7:0]        frame_count
);

  localparam int XW = $clog2(FB_W + 1);
  localparam int YW = $clog2(FB_H + 1);
  localparam int SW = $clog2(TOP_SKIP + 1);

  localparam logic [1:0] ST_SYNC    = 2'd0;
  localparam logic [1:0] ST_SKIP    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]        state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [SW-1:0]     skip_cnt;
  logic [ADDR_W-1:0] row_base;
  logic              vsync_q;
  logic              hblank_q;
  logic              vs_rise;
  logic              hb_rise;

  // Edges are only meaningful on pixel-strobe cycles, so qualify them here.
  assign vs_rise = pix_ce & vsync & ~vsync_q;
  assign hb_rise = pix_ce & hblank & ~hblank_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_SYNC;
      x           <= '0;
      y           <= '0;
      skip_cnt    <= '0;
      row_base    <= '0;
      vsync_q     <= 1'b0;
      hblank_q    <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      fb_we       <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      fb_we       <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        vsync_q  <= vsync;
        hblank_q <= hblank;
        // A new frame overrides line ends and pixels sampled alongside it.
        if (vs_rise) begin
          state       <= ST_SKIP;
          skip_cnt    <= '0;
          x           <= '0;
          y           <= '0;
          row_base    <= '0;
          frame_start <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end else begin
          case (state)
            ST_SKIP: begin
              if (hb_rise) begin
                skip_cnt <= skip_cnt + SW'(1);
                if (skip_cnt == SW'(TOP_SKIP - 1)) begin
                  state    <= ST_CAPTURE;
                  x        <= '0;
                  y        <= '0;
                  row_base <= '0;
                end
              end
            end
            ST_CAPTURE: begin
              if (hb_rise) begin
                x <= '0;
                if (y == YW'(FB_H - 1)) begin
                  state <= ST_DONE;
                end else begin
                  y        <= y + YW'(1);
                  row_base <= row_base + ADDR_W'(FB_W);
                end
              end else if (!hblank && (x < XW'(FB_W))) begin
                fb_we   <= 1'b1;
                fb_addr <= row_base + ADDR_W'(x);
                fb_data <= vblank ? 7'd0 : pix_color;
                x       <= x + XW'(1);
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tia_fb_writer.sv
// tb/tb_tia_fb_writer.sv - scoreboard bench for tia_fb_writer
module tb_tia_fb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_ce;
  logic [6:0]  pix_color;
  logic        hblank;
  logic        vblank;
  logic        vsync;
  logic [15:0] fb_addr;
  logic [6:0]  fb_data;
  logic        fb_we;
  logic        frame_start;
  logic [7:0]  frame_count;

  typedef struct packed {
    logic [15:0] a;
    logic [6:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;
  int          fs_count = 0;
  logic [15:0] last_addr = '0;

  tia_fb_writer dut (
    .clk         (clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .pix_color   (pix_color),
    .hblank      (hblank),
    .vblank      (vblank),
    .vsync       (vsync),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (frame_start === 1'b1) fs_count++;
    if (fb_we === 1'b1) begin
      wr_count++;
      last_addr = fb_addr;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h, required no write", fb_addr, fb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (fb_addr !== mon_e.a || fb_data !== mon_e.d) begin
          n_fail++;
          $display("FAIL write_match: got addr=%0d data=0x%0h, required addr=%0d data=0x%0h",
                   fb_addr, fb_data, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pix(input logic [6:0] c, input logic hb, input logic vb, input logic vs);
    pix_color = c;
    hblank    = hb;
    vblank    = vb;
    vsync     = vs;
    pix_ce    = 1'b1;
    @(posedge clk);
    #1;
    pix_ce    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One TIA line: nhb blank samples then nact visible samples; cap pushes expected writes for row y.
  task automatic line(input int nhb, input int nact, input bit cap, input int y,
                      input bit vb, input int color, input bit gap);
    logic [6:0] c;
    for (int i = 0; i < nhb; i++) pix(7'd0, 1'b1, vb, 1'b0);
    for (int i = 0; i < nact; i++) begin
      c = (color < 0) ? 7'((i * 5 + y) & 127) : 7'(color);
      if (cap && i < 160) exp_q.push_back(wr_t'{a: 16'(y * 160 + i), d: (vb ? 7'd0 : c)});
      pix(c, 1'b0, vb, 1'b0);
      if (gap) idle(1);
    end
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) pix(7'd0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    int w0;
    reset = 1'b0; pix_ce = 1'b0; pix_color = '0; hblank = 1'b0; vblank = 1'b0; vsync = 1'b0;
    idle(3);
    n_checks++; if (fb_we !== 1'b0)       begin n_fail++; $display("FAIL reset_we: got %b, required 0", fb_we); end
    n_checks++; if (fb_addr !== 16'd0)    begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", fb_addr); end
    n_checks++; if (fb_data !== 7'd0)     begin n_fail++; $display("FAIL reset_data: got %0d, required 0", fb_data); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b, required 0", frame_start); end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL reset_fc: got %0d, required 0", frame_count); end
    reset = 1'b1;
    idle(1);
    w0 = wr_count;
    for (int l = 0; l < 3; l++) line(4, 160, 1'b0, 0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (wr_count != w0)       begin n_fail++; $display("FAIL nosync_writes: got %0d, required 0", wr_count - w0); end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL nosync_fc: got %0d, required 0", frame_count); end
    n_checks++; if (fs_count != 0)        begin n_fail++; $display("FAIL nosync_fs: got %0d, required 0", fs_count); end
    n_checks++; if (fb_addr !== 16'd0)    begin n_fail++; $display("FAIL nosync_addr: got %0d, required 0", fb_addr); end
  endtask

  task automatic test_normal_frame();
    int fs0, w0;
    logic [6:0] c;
    fs0 = fs_count;
    vsync_pulse();
    n_checks++; if (fs_count - fs0 != 1)  begin n_fail++; $display("FAIL fs_pulse: got %0d pulse cycles, required 1", fs_count - fs0); end
    n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL fc_one: got %0d, required 1", frame_count); end
    for (int l = 0; l < 30; l++) line(68, 160, 1'b0, 0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 68; i++) pix(7'd0, 1'b1, 1'b0, 1'b0);
    w0 = wr_count;
    exp_q.push_back(wr_t'{a: 16'd0, d: 7'h12});
    pix(7'h12, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== 16'd0 || fb_data !== 7'h12) begin
      n_fail++;
      $display("FAIL first_write: got we=%b addr=%0d data=0x%0h, required we=1 addr=0 data=0x12", fb_we, fb_addr, fb_data);
    end
    for (int i = 1; i < 160; i++) begin
      c = 7'((i * 5) & 127);
      exp_q.push_back(wr_t'{a: 16'(i), d: c});
      pix(c, 1'b0, 1'b0, 1'b0);
    end
    idle(2);
    n_checks++; if (wr_count - w0 != 160) begin n_fail++; $display("FAIL line0_count: got %0d, required 160", wr_count - w0); end
    n_checks++; if (exp_q.size() != 0)   begin n_fail++; $display("FAIL line0_pending: got %0d, required 0", exp_q.size()); end
    n_checks++; if (fb_we !== 1'b0 || fb_addr !== 16'd159) begin n_fail++; $display("FAIL addr_hold: got we=%b addr=%0d, required we=0 addr=159", fb_we, fb_addr); end
    for (int y = 1; y < 240; y++) begin
      w0 = wr_count;
      line(4, (y == 7) ? 175 : 160, 1'b1, y, (y == 10), (y == 10) ? 7'h55 : -1, (y == 3));
      idle(1);
      if (y == 5) begin
        n_checks++; if (last_addr !== 16'd959) begin n_fail++; $display("FAIL line5_last: got %0d, required 959", last_addr); end
      end
      if (y == 7) begin
        n_checks++; if (wr_count - w0 != 160) begin n_fail++; $display("FAIL overlong_count: got %0d, required 160", wr_count - w0); end
      end
      if (y == 239) begin
        n_checks++; if (last_addr !== 16'd38399) begin n_fail++; $display("FAIL last_addr: got %0d, required 38399", last_addr); end
      end
    end
    w0 = wr_count;
    line(4, 160, 1'b0, 0, 1'b0, -1, 1'b0);
    line(4, 160, 1'b0, 0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (wr_count != w0)     begin n_fail++; $display("FAIL done_writes: got %0d, required 0", wr_count - w0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL frame_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_vsync_mid();
    int fs0, w0;
    vsync_pulse();
    n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL fc_two: got %0d, required 2", frame_count); end
    for (int l = 0; l < 30; l++) line(4, 8, 1'b0, 0, 1'b0, -1, 1'b0);
    for (int y = 0; y < 100; y++) line(4, 160, 1'b1, y, 1'b0, -1, 1'b0);
    line(4, 20, 1'b1, 100, 1'b0, -1, 1'b0);
    idle(1);
    fs0 = fs_count;
    w0  = wr_count;
    pix(7'h33, 1'b0, 1'b0, 1'b1);
    pix(7'h33, 1'b0, 1'b0, 1'b1);
    pix(7'h33, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) pix(7'h21, 1'b0, 1'b0, 1'b0);
    n_checks++; if (fs_count - fs0 != 1)  begin n_fail++; $display("FAIL mid_fs: got %0d, required 1", fs_count - fs0); end
    n_checks++; if (frame_count !== 8'd3) begin n_fail++; $display("FAIL mid_fc: got %0d, required 3", frame_count); end
    for (int l = 0; l < 29; l++) line(4, 160, 1'b0, 0, 1'b0, -1, 1'b0);
    idle(1);
    n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL mid_skip_writes: got %0d, required 0", wr_count - w0); end
    line(4, 160, 1'b1, 0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (wr_count - w0 != 160) begin n_fail++; $display("FAIL mid_restart_count: got %0d, required 160", wr_count - w0); end
    n_checks++; if (exp_q.size() != 0)   begin n_fail++; $display("FAIL mid_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (fb_addr !== 16'd0)    begin n_fail++; $display("FAIL async_addr: got %0d, required 0", fb_addr); end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL async_fc: got %0d, required 0", frame_count); end
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_vsync_mid();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
